// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, score width and winner codes for the pong controller
package pong_pkg;
    localparam int SCORE_W = 4;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4,
        PAUSED    = 3'd5
    } state_e;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: counts frame ticks while not cleared; done fires on the tick reaching FRAMES
module pong_frame_timer #(
    parameter int FRAMES = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic done
);
    logic [7:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = clear ? 8'd0 : cnt_q + {7'd0, tick};
        done  = !clear && tick && (cnt_q == 8'(FRAMES - 1));
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game FSM (serve/play/score/win); PONG_PAUSE_EN adds the PAUSED state
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               reset_game,
    output logic               ball_en,
    output logic [SCORE_W-1:0] sc1,
    output logic [SCORE_W-1:0] sc2,
    output logic               serve_dir,
    output logic [1:0]         winner,
    output logic [2:0]         state
);
    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
    state_e             state_q, state_d;
    logic [SCORE_W-1:0] sc1_q, sc1_d, sc2_q, sc2_d;
    logic               dir_q, dir_d, rg_q, rg_d, start_prev_q;
    logic [1:0]         win_q, win_d;
    logic               start_edge, timer_done;
`ifdef PONG_PAUSE_EN
    logic pause_prev_q, pause_edge;
    assign pause_edge = pause_btn && !pause_prev_q;
    always_ff @(posedge clk) begin
        if (reset) pause_prev_q <= 1'b0;
        else       pause_prev_q <= pause_btn;
    end
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
`endif
    assign start_edge = start_btn && !start_prev_q;
    pong_frame_timer #(.FRAMES(SERVE_FRAMES)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (reset || state_q != SERVE),
        .tick  (frame_tick),
        .done  (timer_done)
    );
    always_comb begin
        state_d = state_q;
        sc1_d   = sc1_q;
        sc2_d   = sc2_q;
        dir_d   = dir_q;
        win_d   = win_q;
        case (state_q)
            IDLE, GAME_OVER: if (start_edge) begin
                state_d = SERVE;
                sc1_d   = '0;
                sc2_d   = '0;
                dir_d   = 1'b1;
                win_d   = WIN_NONE;
            end
            SERVE: if (timer_done) state_d = PLAY;
            PLAY: begin
                if (miss_left && miss_right) state_d = SERVE;
                else if (miss_left) begin
                    state_d = POINT;
                    sc2_d   = sc2_q + 4'd1;
                    dir_d   = 1'b0;
                end else if (miss_right) begin
                    state_d = POINT;
                    sc1_d   = sc1_q + 4'd1;
                    dir_d   = 1'b1;
                end
`ifdef PONG_PAUSE_EN
                else if (pause_edge) state_d = PAUSED;
`endif
            end
            POINT: begin
                state_d = (sc1_q == WIN || sc2_q == WIN) ? GAME_OVER : SERVE;
                win_d   = sc1_q == WIN ? WIN_P1 : sc2_q == WIN ? WIN_P2 : win_q;
            end
`ifdef PONG_PAUSE_EN
            PAUSED: if (pause_edge) state_d = PLAY;
`endif
            default: state_d = IDLE;
        endcase
        rg_d = state_d == SERVE && state_q != SERVE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sc1_q        <= '0;
            sc2_q        <= '0;
            dir_q        <= 1'b1;
            win_q        <= WIN_NONE;
            rg_q         <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sc1_q        <= sc1_d;
            sc2_q        <= sc2_d;
            dir_q        <= dir_d;
            win_q        <= win_d;
            rg_q         <= rg_d;
            start_prev_q <= start_btn;
        end
    end
    assign reset_game = rg_q;
    assign ball_en    = state_q == PLAY;
    assign sc1        = sc1_q;
    assign sc2        = sc2_q;
    assign serve_dir  = dir_q;
    assign winner     = win_q;
    assign state      = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed literal checks plus randomized play against a behavioural game model
module tb_pong_game_ctrl;
    localparam int WS = 7;
    localparam int SF = 60;
    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4, S_PAUSED = 5;
    logic clk = 0, reset = 1, frame_tick = 0, start_btn = 0, pause_btn = 0;
    logic miss_left = 0, miss_right = 0;
    logic reset_game, ball_en, serve_dir;
    logic [3:0] sc1, sc2;
    logic [1:0] winner;
    logic [2:0] state;
    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;
    int m_st = 0, m_sc1 = 0, m_sc2 = 0, m_dir = 1, m_win = 0, m_cnt = 0, m_rg = 0;
    int m_ps = 0, m_pp = 0, nst;
    bit se, pe;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .pause_btn(pause_btn), .miss_left(miss_left), .miss_right(miss_right),
        .reset_game(reset_game), .ball_en(ball_en), .sc1(sc1), .sc2(sc2),
        .serve_dir(serve_dir), .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            m_st = S_IDLE; m_sc1 = 0; m_sc2 = 0; m_dir = 1; m_win = 0;
            m_cnt = 0; m_rg = 0; m_ps = 0; m_pp = 0;
        end else begin
            se  = start_btn && m_ps == 0;
            pe  = pause_btn && m_pp == 0;
            nst = m_st;
            if ((m_st == S_IDLE || m_st == S_OVER) && se) begin
                nst = S_SERVE; m_sc1 = 0; m_sc2 = 0; m_dir = 1; m_win = 0;
            end else if (m_st == S_SERVE && frame_tick) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == SF) nst = S_PLAY;
            end else if (m_st == S_PLAY) begin
                if (miss_left && miss_right) nst = S_SERVE;
                else if (miss_left) begin m_sc2++; m_dir = 0; nst = S_POINT; end
                else if (miss_right) begin m_sc1++; m_dir = 1; nst = S_POINT; end
`ifdef PONG_PAUSE_EN
                else if (pe) nst = S_PAUSED;
`endif
            end else if (m_st == S_POINT) begin
                if (m_sc1 == WS || m_sc2 == WS) begin
                    nst = S_OVER;
                    m_win = (m_sc1 == WS) ? 1 : 2;
                end else nst = S_SERVE;
            end else if (m_st == S_PAUSED && pe) nst = S_PLAY;
            m_rg = (nst == S_SERVE && m_st != S_SERVE) ? 1 : 0;
            if (m_rg == 1) m_cnt = 0;
            m_st = nst;
            m_ps = start_btn;
            m_pp = pause_btn;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (state !== 3'(m_st) || sc1 !== 4'(m_sc1) || sc2 !== 4'(m_sc2) ||
                serve_dir !== 1'(m_dir) || winner !== 2'(m_win) ||
                ball_en !== (m_st == S_PLAY) || reset_game !== 1'(m_rg)) begin
                n_bad++;
                $display("FAIL model t=%0t got st=%0d sc=%0d/%0d dir=%0b win=%0d ben=%0b rg=%0b exp st=%0d sc=%0d/%0d dir=%0d win=%0d ben=%0b rg=%0d",
                         $time, state, sc1, sc2, serve_dir, winner, ball_en, reset_game,
                         m_st, m_sc1, m_sc2, m_dir, m_win, m_st == S_PLAY, m_rg);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        start_btn = 1; cyc(1); start_btn = 0;
    endtask

    task automatic ticks(input int n);
        frame_tick = 1; cyc(n); frame_tick = 0;
    endtask

    task automatic pulse_left();
        miss_left = 1; cyc(1); miss_left = 0;
    endtask

    initial begin
        cyc(1);
        chk_en = 1;
        cyc(1);
        chk("rst_state", int'(state), S_IDLE);
        chk("rst_scores", int'({sc1, sc2}), 0);
        chk("rst_dir", int'(serve_dir), 1);
        chk("rst_winner", int'(winner), 0);
        chk("rst_outs", int'({ball_en, reset_game}), 0);
        reset = 0;
        cyc(1);
        press_start();
        chk("start_serve", int'(state), S_SERVE);
        chk("rg_first", int'(reset_game), 1);
        ticks(1);
        chk("rg_once", int'(reset_game), 0);
        ticks(58);
        chk("serve_59", int'(state), S_SERVE);
        ticks(1);
        chk("serve_60_play", int'(state), S_PLAY);
        chk("play_ben", int'(ball_en), 1);
        miss_right = 1; cyc(1); miss_right = 0;
        chk("mr_point", int'(state), S_POINT);
        chk("mr_sc1", int'(sc1), 1);
        chk("mr_dir", int'(serve_dir), 1);
        cyc(1);
        chk("mr_serve", int'({state, reset_game}), S_SERVE * 2 + 1);
        ticks(SF);
        miss_left = 1; miss_right = 1; cyc(1); miss_left = 0; miss_right = 0;
        chk("both_serve", int'(state), S_SERVE);
        chk("both_scores", int'({sc1, sc2}), 8'h10);
        chk("both_dir", int'(serve_dir), 1);
        ticks(30);
        reset = 1; frame_tick = 1; cyc(1); reset = 0; frame_tick = 0;
        chk("midrst_state", int'(state), S_IDLE);
        chk("midrst_outs", int'({sc1, sc2, serve_dir, winner, ball_en, reset_game}), 8'h00 << 5 | 5'b10000);
        press_start();
        repeat (6) begin
            ticks(SF); pulse_left(); cyc(1);
        end
        chk("sc2_six", int'(sc2), 6);
        chk("sc2_six_dir", int'(serve_dir), 0);
        ticks(SF); pulse_left();
        chk("win_point", int'({state, sc2}), S_POINT * 16 + 7);
        cyc(1);
        chk("game_over", int'(state), S_OVER);
        chk("winner_p2", int'(winner), 2);
        miss_right = 1; frame_tick = 1; cyc(3); miss_right = 0; frame_tick = 0;
        chk("over_hold", int'({sc1, sc2, state}), 7 * 8 + S_OVER);
        press_start();
        chk("restart", int'({state, sc1, sc2, winner, serve_dir}), S_SERVE * 2048 + 1);
        repeat (20000) begin
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 15) == 0) pause_btn = ~pause_btn;
            frame_tick = $urandom_range(0, 1) == 1;
            miss_left  = $urandom_range(0, 39) == 0;
            miss_right = $urandom_range(0, 39) == 0;
            reset      = $urandom_range(0, 2999) == 0;
            cyc(1);
        end
        {reset, frame_tick, start_btn, pause_btn, miss_left, miss_right} = '0;
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
